// File: rtl/sar_compare_search.sv
// sar_compare_search: successive-approximation search driving an external magnitude comparator
module sar_compare_search #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic [W-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);
  localparam int KW = W > 1 ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(W - 1);
  localparam logic [W-1:0] MSB = W'(1) << (W - 1);
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  bit_k;
  logic [W-1:0]  kept;
  logic          one_hot;
  assign bit_k   = W'(1) << k;
  assign kept    = cmp_gt ? trial : trial & ~bit_k;
  assign one_hot = {cmp_gt, cmp_eq, cmp_lt} inside {3'b100, 3'b010, 3'b001};
  // search control: keep or clear the current bit from the comparator verdict, then probe the next bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      k      <= K_TOP;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          trial <= MSB;
          k     <= K_TOP;
          err   <= 1'b0;
          busy  <= 1'b1;
          state <= SEARCH;
        end
      end else if (!one_hot) begin
        err    <= 1'b1;
        result <= '0;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else if (cmp_eq) begin
        result <= trial;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else if (k == '0) begin
        result <= kept;
        trial  <= kept;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else begin
        trial <= kept | (bit_k >> 1);
        k     <= k - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sar_compare_search.sv
// tb_sar_compare_search: directed and random searches against a binary-search reference model
module tb_sar_compare_search;
  localparam int W = 3;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_gt, cmp_eq, cmp_lt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;
  int           a_val = 0;
  logic         ov = 1'b0;
  logic [2:0]   ov_v = 3'b000;
  int           checks = 0;
  int           errors = 0;

  sar_compare_search #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .trial(trial), .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  assign cmp_gt = ov ? ov_v[2] : (a_val > int'(trial));
  assign cmp_eq = ov ? ov_v[1] : (a_val == int'(trial));
  assign cmp_lt = ov ? ov_v[0] : (a_val < int'(trial));

  function automatic int exp_trial(input int a, input int i);
    int hi = W - i;
    return ((a >> hi) << hi) | (1 << (W - 1 - i));
  endfunction

  function automatic int steps(input int a);
    for (int i = 0; i < W; i++)
      if (exp_trial(a, i) == a) return i + 1;
    return W;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch_chk(input int a);
    a_val = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("trial0", 32'(trial), 32'(exp_trial(a, 0)));
    chk("busy0", 32'(busy), 1);
  endtask

  task automatic follow(input int a, input bit poke);
    int n = steps(a);
    for (int i = 0; i < n; i++) begin
      if (poke && i == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (i < n - 1) begin
        chk("trial_step", 32'(trial), 32'(exp_trial(a, i + 1)));
        chk("busy_step", 32'(busy), 1);
        chk("done_early", 32'(done), 0);
      end else begin
        chk("done_pulse", 32'(done), 1);
        chk("result", 32'(result), 32'(a));
        chk("err_clean", 32'(err), 0);
        chk("busy_end", 32'(busy), 0);
      end
    end
  endtask

  task automatic drop();
    @(posedge clk); #1;
    chk("done_drop", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    #1;
    chk("rst_trial", 32'(trial), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_err", 32'(err), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    launch_chk(5); follow(5, 0); drop();
    launch_chk(0); follow(0, 0); drop();
    launch_chk(4); follow(4, 0); drop();
    launch_chk(7); follow(7, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_done", 32'(done), 0);
    chk("restart_trial", 32'(trial), 4);
    chk("restart_busy", 32'(busy), 1);
    follow(7, 0); drop();
    launch_chk(5);
    @(posedge clk); #1;
    chk("err_trial1", 32'(trial), 6);
    ov = 1'b1;
    ov_v = 3'b110;
    @(posedge clk); #1;
    chk("err_set", 32'(err), 1);
    chk("err_done", 32'(done), 1);
    chk("err_result", 32'(result), 0);
    chk("err_busy", 32'(busy), 0);
    ov = 1'b0;
    @(posedge clk); #1;
    chk("err_sticky", 32'(err), 1);
    chk("err_done_drop", 32'(done), 0);
    launch_chk(3);
    chk("err_cleared", 32'(err), 0);
    follow(3, 0); drop();
    launch_chk(5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_trial", 32'(trial), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_err", 32'(err), 0);
    #12 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    launch_chk(6); follow(6, 0); drop();
    repeat (20) begin
      int a;
      a = int'($urandom_range(0, (1 << W) - 1));
      launch_chk(a); follow(a, 0); drop();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
